alu_ctrl_issue: RTL and testbench

//  Producer side of the ALU's 4-bit control interface. Decodes MIPS ALUOp/funct/opcode into
//  the ALU control code and issues it to the EX stage through a 2-entry valid/ready skid buffer.

---
 rtl/alu_ctrl_issue_pkg.sv | 45 ++++
 rtl/alu_ctrl_issue_decode.sv | 54 +++++
 rtl/alu_ctrl_issue.sv | 146 ++++++++++++++
 tb/tb_alu_ctrl_issue.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_issue_pkg.sv
// Shared ALU control encodings, decode field values and issue-buffer types.
package alu_ctrl_issue_pkg;

  localparam int unsigned CTRL_W  = 4;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned OPC_W   = 6;

  localparam logic [CTRL_W-1:0] CTRL_AND   = 4'b0000;
  localparam logic [CTRL_W-1:0] CTRL_OR    = 4'b0001;
  localparam logic [CTRL_W-1:0] CTRL_ADD   = 4'b0010;
  localparam logic [CTRL_W-1:0] CTRL_SUB   = 4'b0110;
  localparam logic [CTRL_W-1:0] CTRL_SLT   = 4'b0111;
  localparam logic [CTRL_W-1:0] CTRL_NOR   = 4'b1100;
  localparam logic [CTRL_W-1:0] CTRL_UNDEF = 4'b1111;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR = 6'b100111;

  localparam logic [OPC_W-1:0] OPC_ADDI = 6'b001000;
  localparam logic [OPC_W-1:0] OPC_ANDI = 6'b001100;
  localparam logic [OPC_W-1:0] OPC_ORI  = 6'b001101;
  localparam logic [OPC_W-1:0] OPC_SLTI = 6'b001010;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

  typedef struct packed {
    logic [CTRL_W-1:0] control;
    logic              illegal;
  } alu_op_t;

endpackage

// File: rtl/alu_ctrl_issue_decode.sv
// Combinational MIPS ALUOp/funct/opcode decode into the 4-bit ALU control code.
module alu_ctrl_issue_decode
  import alu_ctrl_issue_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [OPC_W-1:0]   opcode_i,
  output alu_op_t            op_o
);

  always_comb begin
    op_o.control = CTRL_UNDEF;
    op_o.illegal = 1'b1;
    case (aluop_i)
      ALUOP_ADD: begin
        op_o.control = CTRL_ADD;
        op_o.illegal = 1'b0;
      end
      ALUOP_SUB: begin
        op_o.control = CTRL_SUB;
        op_o.illegal = 1'b0;
      end
      ALUOP_RTYPE: begin
        op_o.illegal = 1'b0;
        case (funct_i)
          FUNCT_ADD: op_o.control = CTRL_ADD;
          FUNCT_SUB: op_o.control = CTRL_SUB;
          FUNCT_AND: op_o.control = CTRL_AND;
          FUNCT_OR:  op_o.control = CTRL_OR;
          FUNCT_SLT: op_o.control = CTRL_SLT;
          FUNCT_NOR: op_o.control = CTRL_NOR;
          default: begin
            op_o.control = CTRL_UNDEF;
            op_o.illegal = 1'b1;
          end
        endcase
      end
      default: begin
        op_o.illegal = 1'b0;
        case (opcode_i)
          OPC_ADDI: op_o.control = CTRL_ADD;
          OPC_ANDI: op_o.control = CTRL_AND;
          OPC_ORI:  op_o.control = CTRL_OR;
          OPC_SLTI: op_o.control = CTRL_SLT;
          default: begin
            op_o.control = CTRL_UNDEF;
            op_o.illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_issue.sv
// ALU control issue stage: decoder feeding a 2-entry valid/ready skid buffer toward EX.
// Optional illegal-op tracking is enabled by defining ALU_CTRL_ILLEGAL_TRAP_EN.
module alu_ctrl_issue
  import alu_ctrl_issue_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] in_aluop,
  input  logic [FUNCT_W-1:0] in_funct,
  input  logic [OPC_W-1:0]   in_opcode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_control,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_illegal,
  output logic               illegal_seen
);

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  occ_state_e       state_q, state_d;
  alu_op_t          head_op_q, head_op_d, tail_op_q, tail_op_d;
  logic [TAG_W-1:0] head_tag_q, head_tag_d, tail_tag_q, tail_tag_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             seen_q, seen_d;

  alu_op_t dec_op;
  alu_op_t new_op;
  logic    push;
  logic    pop;

  alu_ctrl_issue_decode u_decode (
    .aluop_i  (in_aluop),
    .funct_i  (in_funct),
    .opcode_i (in_opcode),
    .op_o     (dec_op)
  );

  // Illegal bit is only kept when trap tracking is built in.
  always_comb begin
    new_op.control = dec_op.control;
    new_op.illegal = dec_op.illegal & TRAP_EN;
  end

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  // Head slot doubles as the output register; empty slots are held at zero.
  always_comb begin
    state_d    = state_q;
    head_op_d  = head_op_q;
    head_tag_d = head_tag_q;
    tail_op_d  = tail_op_q;
    tail_tag_d = tail_tag_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          head_op_d  = new_op;
          head_tag_d = in_tag;
          state_d    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          head_op_d  = new_op;
          head_tag_d = in_tag;
        end else if (push) begin
          tail_op_d  = new_op;
          tail_tag_d = in_tag;
          state_d    = ST_FULL;
        end else if (pop) begin
          head_op_d  = '0;
          head_tag_d = '0;
          state_d    = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          head_op_d  = tail_op_q;
          head_tag_d = tail_tag_q;
          tail_op_d  = '0;
          tail_tag_d = '0;
          state_d    = ST_ONE;
        end
      end
      default: begin
        head_op_d  = '0;
        head_tag_d = '0;
        tail_op_d  = '0;
        tail_tag_d = '0;
        state_d    = ST_EMPTY;
      end
    endcase
    if (flush) begin
      head_op_d  = '0;
      head_tag_d = '0;
      tail_op_d  = '0;
      tail_tag_d = '0;
      state_d    = ST_EMPTY;
    end
    seen_d      = seen_q | (push & ~flush & new_op.illegal);
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      head_op_q   <= '0;
      head_tag_q  <= '0;
      tail_op_q   <= '0;
      tail_tag_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      seen_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_op_q   <= head_op_d;
      head_tag_q  <= head_tag_d;
      tail_op_q   <= tail_op_d;
      tail_tag_q  <= tail_tag_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      seen_q      <= seen_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_control  = head_op_q.control;
  assign out_tag      = head_tag_q;
  assign out_illegal  = head_op_q.illegal;
  assign illegal_seen = seen_q;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Directed self-checking bench for alu_ctrl_issue (honours ALU_CTRL_ILLEGAL_TRAP_EN).
module tb_alu_ctrl_issue;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0] in_aluop;
  logic [5:0] in_funct, in_opcode;
  logic [4:0] in_tag, out_tag;
  logic [3:0] out_control;
  logic       out_illegal, illegal_seen;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_ctrl_issue #(.TAG_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_aluop     (in_aluop),
    .in_funct     (in_funct),
    .in_opcode    (in_opcode),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_control  (out_control),
    .out_tag      (out_tag),
    .out_illegal  (out_illegal),
    .illegal_seen (illegal_seen)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic v, input logic [1:0] a, input logic [5:0] f,
                          input logic [5:0] o, input logic [4:0] t);
    in_valid  = v;
    in_aluop  = a;
    in_funct  = f;
    in_opcode = o;
    in_tag    = t;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_control !== 4'b0000) begin n_err++; $display("FAIL reset_control: got %b expected 0000", out_control); end
    n_cmp++; if (out_tag !== 5'd0) begin n_err++; $display("FAIL reset_tag: got %0d expected 0", out_tag); end
    n_cmp++; if (out_illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal: got %b expected 0", out_illegal); end
    n_cmp++; if (illegal_seen !== 1'b0) begin n_err++; $display("FAIL reset_seen: got %b expected 0", illegal_seen); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive_op(1'b1, 2'b10, 6'b100010, 6'd0, 5'd7);
    tick();
    drive_op(1'b0, 2'b00, 6'd0, 6'd0, 5'd0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    n_cmp++; if (out_control !== 4'b0110) begin n_err++; $display("FAIL single_control: got %b expected 0110", out_control); end
    n_cmp++; if (out_tag !== 5'd7) begin n_err++; $display("FAIL single_tag: got %0d expected 7", out_tag); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_control !== 4'b0000) begin n_err++; $display("FAIL single_drain_control: got %b expected 0000", out_control); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive_op(1'b1, 2'b00, 6'd0, 6'd0, 5'd1);
    tick();
    n_cmp++; if (out_control !== 4'b0010) begin n_err++; $display("FAIL b2b_add_control: got %b expected 0010", out_control); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_one_ready: got %b expected 1", in_ready); end
    drive_op(1'b1, 2'b11, 6'd0, 6'b001101, 5'd2);
    tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_ready: got %b expected 0", in_ready); end
    drive_op(1'b1, 2'b10, 6'b101010, 6'd0, 5'd3);
    tick();
    n_cmp++; if (out_control !== 4'b0010 || out_tag !== 5'd1) begin n_err++; $display("FAIL b2b_hold: got %b/%0d expected 0010/1", out_control, out_tag); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_stall: got %b expected 0", in_ready); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_control !== 4'b0001 || out_tag !== 5'd2) begin n_err++; $display("FAIL b2b_or: got %b/%0d expected 0001/2", out_control, out_tag); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_back: got %b expected 1", in_ready); end
    tick();
    drive_op(1'b0, 2'b00, 6'd0, 6'd0, 5'd0);
    n_cmp++; if (out_control !== 4'b0111 || out_tag !== 5'd3) begin n_err++; $display("FAIL b2b_slt: got %b/%0d expected 0111/3", out_control, out_tag); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive_op(1'b1, 2'b00, 6'd0, 6'd0, 5'd4);
    tick();
    drive_op(1'b1, 2'b01, 6'd0, 6'd0, 5'd5);
    tick();
    drive_op(1'b1, 2'b11, 6'd0, 6'b001101, 5'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive_op(1'b0, 2'b00, 6'd0, 6'd0, 5'd0);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL flush_full: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
    n_cmp++; if (out_control !== 4'b0000 || out_tag !== 5'd0) begin n_err++; $display("FAIL flush_outputs: got %b/%0d expected 0000/0", out_control, out_tag); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_lost_full: got %b expected 0", out_valid); end
    drive_op(1'b1, 2'b00, 6'd0, 6'd0, 5'd8);
    tick();
    drive_op(1'b1, 2'b01, 6'd0, 6'd0, 5'd9);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive_op(1'b0, 2'b00, 6'd0, 6'd0, 5'd0);
    tick();
    n_cmp++; if (out_valid !== 1'b0 || out_tag !== 5'd0) begin n_err++; $display("FAIL flush_lost_one: got valid=%b tag=%0d expected 0/0", out_valid, out_tag); end
    n_cmp++; if (illegal_seen !== 1'b0) begin n_err++; $display("FAIL flush_seen_clean: got %b expected 0", illegal_seen); end
  endtask

  task automatic test_stream();
    logic [3:0] exp_c;
    out_ready = 1'b1;
    drive_op(1'b1, 2'd0, 6'b100100, 6'b001010, 5'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      case (i % 4)
        0: exp_c = 4'b0010;
        1: exp_c = 4'b0110;
        2: exp_c = 4'b0000;
        default: exp_c = 4'b0111;
      endcase
      n_cmp++; if (out_valid !== 1'b1 || out_control !== exp_c || out_tag !== 5'(i + 1))
        begin n_err++; $display("FAIL stream_%0d: got v=%b c=%b t=%0d expected 1/%b/%0d", i, out_valid, out_control, out_tag, exp_c, i + 1); end
      if (i < 19) drive_op(1'b1, 2'((i + 1) % 4), 6'b100100, 6'b001010, 5'(i + 2));
      else drive_op(1'b0, 2'd0, 6'd0, 6'd0, 5'd0);
    end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_decode();
    logic [1:0] ta [10];
    logic [5:0] tf [10];
    logic [5:0] to [10];
    logic [3:0] tc [10];
    logic       ti [10];
    ta = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b01};
    tf = '{6'b100000, 6'b100101, 6'b100111, 6'b101010, 6'b100100, 6'b111111, 6'd0, 6'd0, 6'd0, 6'b111111};
    to = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'b001000, 6'b001100, 6'b000000, 6'd0};
    tc = '{4'b0010, 4'b0001, 4'b1100, 4'b0111, 4'b0000, 4'b1111, 4'b0010, 4'b0000, 4'b1111, 4'b0110};
    ti = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_op(1'b1, ta[i], tf[i], to[i], 5'(20 + i));
      tick();
      n_cmp++; if (out_control !== tc[i] || out_tag !== 5'(20 + i))
        begin n_err++; $display("FAIL decode_%0d: got %b/%0d expected %b/%0d", i, out_control, out_tag, tc[i], 20 + i); end
      n_cmp++; if (out_illegal !== (ti[i] & TRAP))
        begin n_err++; $display("FAIL decode_illegal_%0d: got %b expected %b", i, out_illegal, ti[i] & TRAP); end
    end
    drive_op(1'b0, 2'd0, 6'd0, 6'd0, 5'd0);
    tick();
    n_cmp++; if (illegal_seen !== TRAP) begin n_err++; $display("FAIL decode_seen: got %b expected %b", illegal_seen, TRAP); end
  endtask

  task automatic test_illegal_flush();
    out_ready = 1'b0;
    drive_op(1'b1, 2'b10, 6'b111111, 6'd0, 5'd9);
    tick();
    drive_op(1'b0, 2'd0, 6'd0, 6'd0, 5'd0);
    n_cmp++; if (out_control !== 4'b1111 || out_tag !== 5'd9) begin n_err++; $display("FAIL illegal_control: got %b/%0d expected 1111/9", out_control, out_tag); end
    n_cmp++; if (out_illegal !== TRAP) begin n_err++; $display("FAIL illegal_head: got %b expected %b", out_illegal, TRAP); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || out_illegal !== 1'b0) begin n_err++; $display("FAIL illegal_flush_out: got v=%b i=%b expected 0/0", out_valid, out_illegal); end
    n_cmp++; if (illegal_seen !== TRAP) begin n_err++; $display("FAIL illegal_seen_sticky: got %b expected %b", illegal_seen, TRAP); end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    drive_op(1'b1, 2'b01, 6'd0, 6'd0, 5'd11);
    tick();
    drive_op(1'b1, 2'b00, 6'd0, 6'd0, 5'd12);
    tick();
    drive_op(1'b0, 2'd0, 6'd0, 6'd0, 5'd0);
    n_cmp++; if (in_ready !== 1'b0 || out_control !== 4'b0110) begin n_err++; $display("FAIL rstfull_pre: got ready=%b c=%b expected 0/0110", in_ready, out_control); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL rstfull_hs: got ready=%b valid=%b expected 1/0", in_ready, out_valid); end
    n_cmp++; if (out_control !== 4'b0000 || out_tag !== 5'd0 || out_illegal !== 1'b0 || illegal_seen !== 1'b0)
      begin n_err++; $display("FAIL rstfull_out: got c=%b t=%0d i=%b s=%b expected 0000/0/0/0", out_control, out_tag, out_illegal, illegal_seen); end
    tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstfull_discard: got %b expected 0", out_valid); end
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive_op(1'b0, 2'd0, 6'd0, 6'd0, 5'd0);
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_stream();
    test_decode();
    test_illegal_flush();
    test_reset_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
